shift_add_mult_datapath: RTL and testbench
==========================================

Name: shift_add_mult_datapath

Overview:
- Datapath of a 32x32 unsigned sequential shift-add multiplier; driven cycle-by-cycle by an external controller through the add/shr/incr strobes.
- Holds a 64-bit product/multiplier register, a 1-bit carry register and a 6-bit iteration counter.
- Reports the current multiplier LSB and a loop-not-done flag back to the controller.
- Built structurally from adder_32b (product-high adder), adder_6b (counter incrementer) and mux_2x1 (all selection).

Parameters:
- none. Operand width is fixed at 32 bits, product width at 64 bits and counter width at 6 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset; also acts as the start/load command
- multiplicand  input  32  unsigned operand added into the product high half
- multiplier  input  32  unsigned operand loaded into the product low half at reset
- shr  input  1  shift the product (with carry) right by one this cycle
- add  input  1  add multiplicand into product[63:32] this cycle
- incr  input  1  increment the iteration counter this cycle
- write  output  1  equals product[0]: the current multiplier bit (controller asserts add when 1)
- less32  output  1  equals NOT counter[5]: 1 while counter < 32
- result  output  64  registered copy of the product as updated this cycle

Behaviour:
- Registers: product[63:0], carry (1 bit), counter[5:0], result[63:0].
- Reset (rst=1 at a clk edge):
  - product <= {32'h0, multiplier}
  - carry <= 0
  - counter <= 0
  - result <= 0
  - Reset has priority over all strobes; asserting it mid-operation aborts and reloads.
- Combinational add stage:
  - addend = add ? multiplicand : 0 (via mux_2x1)
  - {c, sum} = adder_32b(addend, product[63:32], cin=0)
  - temp = {sum, product[31:0]}
  - tc = add ? c : carry
- Shift stage:
  - shifted = {tc, temp[63:1]}
  - next_product = shr ? shifted : temp
  - next_carry = shr ? 0 : tc
- Counter:
  - inc = adder_6b(counter, 6'd1, 0)
  - next_counter = incr ? inc : counter
  - Wraps 63 -> 0; no saturation.
- Non-reset clock edge:
  - product <= next_product
  - carry <= next_carry
  - counter <= next_counter
  - result <= next_product
  - result therefore shows the new product value after the same edge that updates product (one-cycle register latency from the strobes).
- Strobe combinations:
  - add and shr together in one cycle: add first, then shift (carry out of the add enters bit 63).
  - All strobes low: product, carry and counter hold; result is refreshed to the held product.
  - Strobes are independent; incr may coincide with either operation.
- Outputs write and less32 are combinational from the registers, so they are valid one cycle after the edge that changes them.
- Nominal controller sequence per iteration:
  - add = write, shr = 1, incr = 1 in one cycle; or add in one cycle, then shr+incr in the next (the carry register preserves bit 64).
  - Stop when less32 = 0 (counter = 32). product then holds the full 64-bit unsigned product.
- Arithmetic is unsigned throughout. Overflow beyond 64 bits is impossible when the sequence is followed.

Test Plan:
- Reset load: multiplier = 32'h0000_0005, rst = 1 for one edge -> product = 64'h0000_0000_0000_0005, write = 1, less32 = 1, counter = 0, result = 0.
- Small multiply: 3 x 5, 32 iterations of (add = write, shr = 1, incr = 1) -> result = 64'h0000_0000_0000_000F, less32 = 0 after the 32nd edge.
- Carry path: 32'hFFFF_FFFF x 32'hFFFF_FFFF, in both the single-cycle iteration style and the split add-then-shift style -> result = 64'hFFFF_FFFE_0000_0001.
- Hold: all strobes low for 5 cycles mid-operation -> product and counter unchanged, result equals product.
- Counter boundary: incr alone 32 times -> less32 falls to 0 exactly when counter = 32. Continued incr to 64 edges -> counter wraps to 0 and less32 = 1.
- Reset mid-operation: assert rst after 10 iterations with multiplier = 7 -> product = {32'h0, 32'h7}, carry = 0, counter = 0 on the next edge. Then 7 x 9 completes to 64'd63.

Source files
------------

// File: rtl/shift_add_mult_datapath_if.sv
// Controller <-> datapath bundle for the shift-add multiplier.
// The controller drives operands and strobes; the datapath reports back
// the current multiplier bit, the loop flag and the product.
interface shift_add_mult_datapath_if;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        shr;
    logic        add;
    logic        incr;
    logic        write;
    logic        less32;
    logic [63:0] result;

    modport master (
        output multiplicand, multiplier, shr, add, incr,
        input  write, less32, result
    );

    modport slave (
        input  multiplicand, multiplier, shr, add, incr,
        output write, less32, result
    );
endinterface

// File: rtl/shift_add_mult_datapath.sv
// Datapath of a 32x32 unsigned sequential shift-add multiplier.
// Holds the 64-bit product/multiplier register, a carry bit that keeps
// bit 64 alive between an add cycle and a later shift cycle, and a 6-bit
// iteration counter. Sequencing comes from an external controller.

// Generic two-input selector: y = sel ? b : a.
module mux_2x1 #(
    parameter int WIDTH = 1
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    // Pure selection, no state.
    always_comb begin
        y = sel ? b : a;
    end
endmodule

// 32-bit unsigned ripple adder with carry in/out.
module adder_32b (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    // Full-width add; the carry out becomes the product's bit 64.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {32'h0, cin};
    end
endmodule

// 6-bit incrementer-style adder; wraps modulo 64.
module adder_6b (
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       cin,
    output logic [5:0] sum
);
    // Carry out is intentionally dropped so the counter wraps 63 -> 0.
    always_comb begin
        sum = a + b + {5'h0, cin};
    end
endmodule

module shift_add_mult_datapath (
    input  logic                          clk,
    input  logic                          rst,
    shift_add_mult_datapath_if.slave      bus
);
    logic [63:0] product;
    logic        carry;
    logic [5:0]  counter;
    logic [63:0] result_q;

    logic [31:0] addend;
    logic [31:0] sum;
    logic        c;
    logic [63:0] temp;
    logic        tc;
    logic [63:0] shifted;
    logic [63:0] next_product;
    logic        next_carry;
    logic [5:0]  inc;
    logic [5:0]  next_counter;

    // Add stage: optionally add the multiplicand into the high half.
    mux_2x1 #(.WIDTH(32)) u_addend_mux (
        .sel (bus.add),
        .a   (32'h0),
        .b   (bus.multiplicand),
        .y   (addend)
    );

    adder_32b u_hi_adder (
        .a    (addend),
        .b    (product[63:32]),
        .cin  (1'b0),
        .sum  (sum),
        .cout (c)
    );

    assign temp = {sum, product[31:0]};

    // Without an add this cycle, the stored carry from an earlier add is
    // the bit that must shift into position 63.
    mux_2x1 #(.WIDTH(1)) u_tc_mux (
        .sel (bus.add),
        .a   (carry),
        .b   (c),
        .y   (tc)
    );

    // Shift stage: add happens first, then the 65-bit value shifts right.
    assign shifted = {tc, temp[63:1]};

    mux_2x1 #(.WIDTH(64)) u_product_mux (
        .sel (bus.shr),
        .a   (temp),
        .b   (shifted),
        .y   (next_product)
    );

    mux_2x1 #(.WIDTH(1)) u_carry_mux (
        .sel (bus.shr),
        .a   (tc),
        .b   (1'b0),
        .y   (next_carry)
    );

    // Iteration counter.
    adder_6b u_cnt_inc (
        .a   (counter),
        .b   (6'd1),
        .cin (1'b0),
        .sum (inc)
    );

    mux_2x1 #(.WIDTH(6)) u_counter_mux (
        .sel (bus.incr),
        .a   (counter),
        .b   (inc),
        .y   (next_counter)
    );

    // State update; reset doubles as the load/start command and wins over strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            product  <= {32'h0, bus.multiplier};
            carry    <= 1'b0;
            counter  <= 6'd0;
            result_q <= 64'h0;
        end else begin
            product  <= next_product;
            carry    <= next_carry;
            counter  <= next_counter;
            result_q <= next_product;
        end
    end

    assign bus.write  = product[0];
    assign bus.less32 = ~counter[5];
    assign bus.result = result_q;
endmodule

// File: tb/tb_shift_add_mult_datapath.sv
// Self-checking bench for shift_add_mult_datapath: table of directed
// multiplies, hand-written corner sequences and randomized strobe traffic
// compared against a 65-bit arithmetic reference model.
module tb_shift_add_mult_datapath;
    logic clk;
    logic rst;

    shift_add_mult_datapath_if bus();

    shift_add_mult_datapath dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: 64-bit product plus pending bit 64 and an iteration count.
    logic [63:0] m_prod;
    logic        m_carry;
    int          m_cnt;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          style;   // 0: add+shr+incr in one cycle, 1: add then shr+incr
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset(input logic [31:0] b);
        m_prod  = {32'h0, b};
        m_carry = 1'b0;
        m_cnt   = 0;
    endtask

    // Treat {carry, product[63:32]} as a 33-bit high part; add, then shift the 65-bit value.
    task automatic model_step(input logic a, input logic s, input logic i, input logic [31:0] mc);
        logic [32:0] hi;
        logic [64:0] full;
        if (a) hi = {1'b0, m_prod[63:32]} + {1'b0, mc};
        else   hi = {m_carry, m_prod[63:32]};
        full = {hi, m_prod[31:0]};
        if (s) begin
            full = full >> 1;
            m_prod  = full[63:0];
            m_carry = 1'b0;
        end else begin
            m_prod  = full[63:0];
            m_carry = full[64];
        end
        if (i) m_cnt = (m_cnt + 1) % 64;
    endtask

    task automatic check_model(input string name);
        chk({name, "_result"}, bus.result, m_prod);
        chk({name, "_write"},  {63'h0, bus.write}, {63'h0, m_prod[0]});
        chk({name, "_less32"}, {63'h0, bus.less32}, {63'h0, (m_cnt < 32)});
    endtask

    task automatic do_reset(input logic [31:0] b);
        bus.multiplier = b;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset(b);
        chk("reset_result", bus.result, 64'h0);
        chk("reset_write", {63'h0, bus.write}, {63'h0, b[0]});
        chk("reset_less32", {63'h0, bus.less32}, 64'h1);
    endtask

    task automatic apply(input logic a, input logic s, input logic i, input string name);
        bus.add  = a;
        bus.shr  = s;
        bus.incr = i;
        tick();
        model_step(a, s, i, bus.multiplicand);
        check_model(name);
        bus.add  = 1'b0;
        bus.shr  = 1'b0;
        bus.incr = 1'b0;
    endtask

    task automatic iterate(input int style);
        if (style == 0) begin
            apply(m_prod[0], 1'b1, 1'b1, "iter1");
        end else begin
            apply(m_prod[0], 1'b0, 1'b0, "iter_add");
            apply(1'b0, 1'b1, 1'b1, "iter_shr");
        end
    endtask

    task automatic multiply(input logic [31:0] a, input logic [31:0] b, input int style,
                            input logic [63:0] exp, input string name);
        bus.multiplicand = a;
        do_reset(b);
        for (int k = 0; k < 32; k++) iterate(style);
        chk({name, "_product"}, bus.result, exp);
        chk({name, "_done"}, {63'h0, bus.less32}, 64'h0);
    endtask

    initial begin
        vecs[0] = '{32'd3,          32'd5,          0, 64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1, 64'hFFFF_FFFE_0000_0001};
        vecs[3] = '{32'd0,          32'hFFFF_FFFF,  0, 64'h0};
        vecs[4] = '{32'd1,          32'hFFFF_FFFF,  1, 64'h0000_0000_FFFF_FFFF};
        vecs[5] = '{32'h8000_0000,  32'h8000_0000,  1, 64'h4000_0000_0000_0000};
        vecs[6] = '{32'hFFFF_FFFF,  32'd2,          0, 64'h0000_0001_FFFF_FFFE};
        vecs[7] = '{32'd9,          32'd7,          1, 64'd63};

        rst = 1'b0;
        bus.multiplicand = 32'h0;
        bus.multiplier   = 32'h0;
        bus.add  = 1'b0;
        bus.shr  = 1'b0;
        bus.incr = 1'b0;
        tick();

        // Reset load and hold refresh of result.
        bus.multiplicand = 32'd3;
        do_reset(32'h0000_0005);
        apply(1'b0, 1'b0, 1'b0, "after_reset_idle");
        chk("reset_product", bus.result, 64'h5);

        // Directed table.
        for (int v = 0; v < 8; v++)
            multiply(vecs[v].a, vecs[v].b, vecs[v].style, vecs[v].exp, "table");

        // Hold mid-operation.
        bus.multiplicand = 32'hDEAD_BEEF;
        do_reset(32'h1234_5679);
        for (int k = 0; k < 10; k++) iterate(0);
        apply(m_prod[0], 1'b0, 1'b0, "pre_hold_add");
        for (int k = 0; k < 5; k++) apply(1'b0, 1'b0, 1'b0, "hold");
        apply(1'b0, 1'b1, 1'b1, "post_hold_shr");
        for (int k = 0; k < 21; k++) iterate(1);
        chk("hold_product", bus.result, 64'hDEAD_BEEF * 64'h1234_5679);

        // Counter boundary and wrap.
        do_reset(32'hA5A5_A5A5);
        for (int k = 1; k <= 64; k++) begin
            apply(1'b0, 1'b0, 1'b1, "incr_only");
            if (k == 31) chk("cnt31_less32", {63'h0, bus.less32}, 64'h1);
            if (k == 32) chk("cnt32_less32", {63'h0, bus.less32}, 64'h0);
            if (k == 64) chk("cnt_wrap_less32", {63'h0, bus.less32}, 64'h1);
        end
        chk("incr_only_product", bus.result, 64'hA5A5_A5A5);

        // Reset mid-operation, then a clean 7 x 9.
        bus.multiplicand = 32'd9;
        do_reset(32'd7);
        for (int k = 0; k < 10; k++) iterate(0);
        apply(1'b1, 1'b0, 1'b0, "leave_carry");
        bus.add = 1'b1; bus.shr = 1'b1; bus.incr = 1'b1;
        do_reset(32'd7);
        bus.add = 1'b0; bus.shr = 1'b0; bus.incr = 1'b0;
        apply(1'b0, 1'b1, 1'b0, "post_reset_shr");
        chk("midreset_carry_clear", bus.result, 64'h3);
        do_reset(32'd7);
        for (int k = 0; k < 32; k++) iterate(0);
        chk("midreset_7x9", bus.result, 64'd63);

        // Randomized complete multiplies against plain multiplication.
        for (int r = 0; r < 12; r++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            multiply(ra, rb, r % 2, {32'h0, ra} * {32'h0, rb}, "rand_mult");
        end

        // Randomized strobe traffic with occasional reloads.
        bus.multiplicand = $urandom;
        do_reset($urandom);
        for (int r = 0; r < 300; r++) begin
            if ($urandom_range(0, 39) == 0) begin
                bus.multiplicand = $urandom;
                do_reset($urandom);
            end else begin
                apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), "rand_strobe");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
